// File: rtl/clock_ratio_pkg.sv
// Shared types and helpers for the clock ratio monitor.
// Holds the FSM state encoding, default counter width and a saturating increment.
package clock_ratio_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TRACK   = 2'd2
   } state_t;

   localparam int DEFAULT_CNT_W = 8;
   localparam int MATCH_W       = 4;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
      if (value >= max) begin
         return max;
      end
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/clock_ratio_edge_det.sv
// Registers the already clk-synchronous sig_in once and flags its rising and falling edges.
module clock_ratio_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign rise = sig_in & ~sig_q;
   assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures period/high/low time of a slow signal in clk cycles, tracks lock and flags errors.
// Optional duty-cycle qualification of lock: define CLOCK_RATIO_MONITOR_DUTY_CHECK_EN.
module clock_ratio_monitor
   import clock_ratio_pkg::*;
#(
   parameter int CNT_W      = DEFAULT_CNT_W,
   parameter int LOCK_COUNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             err_timeout,
   output logic             err_mismatch
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
   ,
   output logic             duty_ok
`endif
);

   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_COUNT);

   logic rise;
   logic fall;

   state_t state_q, state_d;

   logic [CNT_W-1:0]   cnt_per_q, cnt_per_d;
   logic [CNT_W-1:0]   cnt_hi_q, cnt_hi_d;
   logic [CNT_W-1:0]   cnt_lo_q, cnt_lo_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_time_q, high_time_d;
   logic [CNT_W-1:0]   low_time_q, low_time_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic               meas_valid_q, meas_valid_d;
   logic               locked_q, locked_d;
   logic               err_timeout_q, err_timeout_d;
   logic               err_mismatch_q, err_mismatch_d;

   logic timeout;
   logic same_period;
   logic duty_gate;

   clock_ratio_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (rise),
      .fall   (fall)
   );

   // A rise coinciding with counter saturation is a valid edge, never a timeout.
   assign timeout     = (state_q != IDLE) && !rise && (cnt_per_q == CNT_MAX);
   assign same_period = (cnt_per_q == period_q);

`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
   logic             duty_ok_q, duty_ok_d;
   logic [CNT_W-1:0] hl_diff;
   logic             duty_now;

   assign hl_diff   = (cnt_hi_q >= cnt_lo_q) ? (cnt_hi_q - cnt_lo_q) : (cnt_lo_q - cnt_hi_q);
   assign duty_now  = (hl_diff <= CNT_ONE);
   assign duty_gate = duty_ok_q;
   assign duty_ok   = duty_ok_q;
`else
   assign duty_gate = 1'b1;
`endif

   always_comb begin
      cnt_per_d = rise ? CNT_ONE : CNT_W'(sat_inc(32'(cnt_per_q), 32'(CNT_MAX)));

      cnt_hi_d = cnt_hi_q;
      if (rise) begin
         cnt_hi_d = CNT_ONE;
      end else if (sig_in) begin
         cnt_hi_d = CNT_W'(sat_inc(32'(cnt_hi_q), 32'(CNT_MAX)));
      end

      cnt_lo_d = cnt_lo_q;
      if (fall) begin
         cnt_lo_d = CNT_ONE;
      end else if (!sig_in) begin
         cnt_lo_d = CNT_W'(sat_inc(32'(cnt_lo_q), 32'(CNT_MAX)));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               state_d = TRACK;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         TRACK: begin
            if (timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      period_d       = period_q;
      high_time_d    = high_time_q;
      low_time_d     = low_time_q;
      match_cnt_d    = match_cnt_q;
      locked_d       = locked_q;
      meas_valid_d   = 1'b0;
      err_timeout_d  = 1'b0;
      err_mismatch_d = 1'b0;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
      duty_ok_d      = duty_ok_q;
`endif

      if (rise && (state_q != IDLE)) begin
         period_d     = cnt_per_q;
         high_time_d  = cnt_hi_q;
         low_time_d   = cnt_lo_q;
         meas_valid_d = 1'b1;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
         duty_ok_d    = duty_now;
`endif
      end

      case (state_q)
         MEASURE: begin
            if (rise) begin
               match_cnt_d = MATCH_W'(1);
            end
         end
         TRACK: begin
            if (rise && !same_period) begin
               match_cnt_d = MATCH_W'(1);
               if (locked_q) begin
                  locked_d       = 1'b0;
                  err_mismatch_d = 1'b1;
               end
            end else begin
               if (rise) begin
                  match_cnt_d = MATCH_W'(sat_inc(32'(match_cnt_q), 32'(LOCK_COUNT)));
               end
               // Lock follows the registered match count, so it lands one cycle later.
               if ((match_cnt_q == LOCK_MATCH) && duty_gate) begin
                  locked_d = 1'b1;
               end else if (!duty_gate) begin
                  locked_d = 1'b0;
               end
            end
         end
         default: ;
      endcase

      if (timeout) begin
         locked_d      = 1'b0;
         match_cnt_d   = '0;
         err_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_per_q      <= '0;
         cnt_hi_q       <= '0;
         cnt_lo_q       <= '0;
         period_q       <= '0;
         high_time_q    <= '0;
         low_time_q     <= '0;
         match_cnt_q    <= '0;
         meas_valid_q   <= 1'b0;
         locked_q       <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_mismatch_q <= 1'b0;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
         duty_ok_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_per_q      <= cnt_per_d;
         cnt_hi_q       <= cnt_hi_d;
         cnt_lo_q       <= cnt_lo_d;
         period_q       <= period_d;
         high_time_q    <= high_time_d;
         low_time_q     <= low_time_d;
         match_cnt_q    <= match_cnt_d;
         meas_valid_q   <= meas_valid_d;
         locked_q       <= locked_d;
         err_timeout_q  <= err_timeout_d;
         err_mismatch_q <= err_mismatch_d;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
         duty_ok_q      <= duty_ok_d;
`endif
      end
   end

   assign period       = period_q;
   assign high_time    = high_time_q;
   assign low_time     = low_time_q;
   assign meas_valid   = meas_valid_q;
   assign locked       = locked_q;
   assign err_timeout  = err_timeout_q;
   assign err_mismatch = err_mismatch_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed self-checking bench for clock_ratio_monitor (CNT_W=8, LOCK_COUNT=2).
// Duty-check scenario is compiled in when CLOCK_RATIO_MONITOR_DUTY_CHECK_EN is defined.
module tb_clock_ratio_monitor;
   import clock_ratio_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sig_in = 1'b0;
   logic [7:0] period, high_time, low_time;
   logic       meas_valid, locked, err_timeout, err_mismatch;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
   logic       duty_ok;
`endif

   int checks = 0;
   int errors = 0;
   int mv_tot = 0;
   int mm_tot = 0;
   int to_tot = 0;

   clock_ratio_monitor #(.CNT_W(8), .LOCK_COUNT(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .low_time     (low_time),
      .meas_valid   (meas_valid),
      .locked       (locked),
      .err_timeout  (err_timeout),
      .err_mismatch (err_mismatch)
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
      ,
      .duty_ok      (duty_ok)
`endif
   );

   always #5 clk = ~clk;

   // Pulse tallies, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (meas_valid === 1'b1) mv_tot <= mv_tot + 1;
         if (err_mismatch === 1'b1) mm_tot <= mm_tot + 1;
         if (err_timeout === 1'b1) to_tot <= to_tot + 1;
      end
   end

   // One clk cycle with sig_in = v; returns 1 time unit after the edge.
   task automatic drive(input logic v);
      sig_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic gen(input int hi, input int lo, input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < hi; i++) drive(1'b1);
         for (int i = 0; i < lo; i++) drive(1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0);
      drive(1'b0);
      checks++; if (period !== 8'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
      checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_time); end
      checks++; if (low_time !== 8'd0) begin errors++; $display("FAIL reset_low got %0d exp 0", low_time); end
      checks++; if ({meas_valid, locked, err_timeout, err_mismatch} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {meas_valid, locked, err_timeout, err_mismatch});
      end
      rst = 1'b0;
   endtask

   task automatic test_div2();
      do_reset();
      drive(1'b1);
      checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL div2_first_rise_mv got %0d exp 0", meas_valid); end
      drive(1'b0);
      drive(1'b1);
      checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL div2_mv got %0d exp 1", meas_valid); end
      checks++; if (period !== 8'd2) begin errors++; $display("FAIL div2_period got %0d exp 2", period); end
      checks++; if (high_time !== 8'd1) begin errors++; $display("FAIL div2_high got %0d exp 1", high_time); end
      checks++; if (low_time !== 8'd1) begin errors++; $display("FAIL div2_low got %0d exp 1", low_time); end
      drive(1'b0);
      checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL div2_mv_pulse got %0d exp 0", meas_valid); end
      drive(1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL div2_lock_early got %0d exp 0", locked); end
      drive(1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL div2_locked got %0d exp 1", locked); end
   endtask

   task automatic test_div8();
      int mv0, mm0, to0;
      do_reset();
      mv0 = mv_tot; mm0 = mm_tot; to0 = to_tot;
      gen(4, 4, 4);
      checks++; if (period !== 8'd8) begin errors++; $display("FAIL div8_period got %0d exp 8", period); end
      checks++; if (high_time !== 8'd4) begin errors++; $display("FAIL div8_high got %0d exp 4", high_time); end
      checks++; if (low_time !== 8'd4) begin errors++; $display("FAIL div8_low got %0d exp 4", low_time); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL div8_locked got %0d exp 1", locked); end
      checks++; if (mv_tot - mv0 !== 3) begin errors++; $display("FAIL div8_mv_count got %0d exp 3", mv_tot - mv0); end
      checks++; if ((mm_tot - mm0) + (to_tot - to0) !== 0) begin
         errors++; $display("FAIL div8_err_pulses got %0d exp 0", (mm_tot - mm0) + (to_tot - to0));
      end
   endtask

   task automatic test_mismatch();
      int mm0;
      do_reset();
      gen(2, 2, 4);
      mm0 = mm_tot;
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mm_div4_locked got %0d exp 1", locked); end
      gen(8, 8, 1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mm_still_locked got %0d exp 1", locked); end
      drive(1'b1);
      checks++; if (err_mismatch !== 1'b1) begin errors++; $display("FAIL mm_pulse got %0d exp 1", err_mismatch); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_unlock got %0d exp 0", locked); end
      checks++; if (period !== 8'd16) begin errors++; $display("FAIL mm_period got %0d exp 16", period); end
      drive(1'b1);
      checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL mm_pulse_width got %0d exp 0", err_mismatch); end
      for (int i = 0; i < 6; i++) drive(1'b1);
      for (int i = 0; i < 8; i++) drive(1'b0);
      drive(1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_relock_early got %0d exp 0", locked); end
      drive(1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mm_relock got %0d exp 1", locked); end
      drive(1'b1);
      checks++; if (mm_tot - mm0 !== 1) begin errors++; $display("FAIL mm_count got %0d exp 1", mm_tot - mm0); end
   endtask

   task automatic test_timeout();
      int k;
      int tot0;
      do_reset();
      gen(2, 2, 3);
      drive(1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_locked got %0d exp 1", locked); end
      k = 0;
      do begin
         drive(1'b0);
         k++;
      end while (err_timeout !== 1'b1 && k < 400);
      checks++; if (k !== 255) begin errors++; $display("FAIL to_latency got %0d exp 255", k); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_unlock got %0d exp 0", locked); end
      checks++; if (period !== 8'd4) begin errors++; $display("FAIL to_period_hold got %0d exp 4", period); end
      checks++; if ({high_time, low_time} !== {8'd2, 8'd2}) begin
         errors++; $display("FAIL to_hl_hold got %0d/%0d exp 2/2", high_time, low_time);
      end
      drive(1'b0);
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %0d exp 0", err_timeout); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL to_state got %0d exp %0d", dut.state_q, IDLE); end
      tot0 = mv_tot + mm_tot + to_tot;
      for (int i = 0; i < 300; i++) drive(1'b0);
      checks++; if (mv_tot + mm_tot + to_tot - tot0 !== 0) begin
         errors++; $display("FAIL to_stuck_low_pulses got %0d exp 0", mv_tot + mm_tot + to_tot - tot0);
      end
   endtask

   task automatic test_idle_stuck();
      int tot0;
      do_reset();
      tot0 = mv_tot + mm_tot + to_tot;
      for (int i = 0; i < 300; i++) drive(1'b0);
      checks++; if (mv_tot + mm_tot + to_tot - tot0 !== 0) begin
         errors++; $display("FAIL idle_stuck_pulses got %0d exp 0", mv_tot + mm_tot + to_tot - tot0);
      end
   endtask

   task automatic test_max_period();
      int mv0, to0;
      do_reset();
      mv0 = mv_tot; to0 = to_tot;
      gen(127, 128, 3);
      checks++; if (period !== 8'd255) begin errors++; $display("FAIL max_period got %0d exp 255", period); end
      checks++; if (high_time !== 8'd127) begin errors++; $display("FAIL max_high got %0d exp 127", high_time); end
      checks++; if (low_time !== 8'd128) begin errors++; $display("FAIL max_low got %0d exp 128", low_time); end
      checks++; if (to_tot - to0 !== 0) begin errors++; $display("FAIL max_timeouts got %0d exp 0", to_tot - to0); end
      checks++; if (mv_tot - mv0 !== 2) begin errors++; $display("FAIL max_mv_count got %0d exp 2", mv_tot - mv0); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL max_locked got %0d exp 1", locked); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      gen(2, 2, 4);
      drive(1'b1);
      drive(1'b1);
      drive(1'b0);
      rst = 1'b1;
      drive(1'b0);
      checks++; if ({period, high_time, low_time} !== 24'd0) begin
         errors++; $display("FAIL rmid_values got %0d/%0d/%0d exp 0/0/0", period, high_time, low_time);
      end
      checks++; if ({meas_valid, locked, err_timeout, err_mismatch} !== 4'b0000) begin
         errors++; $display("FAIL rmid_flags got %b exp 0000", {meas_valid, locked, err_timeout, err_mismatch});
      end
      rst = 1'b0;
      drive(1'b0);
      drive(1'b1);
      checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rmid_first_rise_mv got %0d exp 0", meas_valid); end
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
      drive(1'b1);
      checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL rmid_second_rise_mv got %0d exp 1", meas_valid); end
      checks++; if ({period, high_time, low_time} !== {8'd4, 8'd2, 8'd2}) begin
         errors++; $display("FAIL rmid_meas got %0d/%0d/%0d exp 4/2/2", period, high_time, low_time);
      end
   endtask

`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
   task automatic test_duty();
      do_reset();
      gen(3, 5, 4);
      checks++; if (period !== 8'd8) begin errors++; $display("FAIL duty_period got %0d exp 8", period); end
      checks++; if (duty_ok !== 1'b0) begin errors++; $display("FAIL duty_bad got %0d exp 0", duty_ok); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL duty_no_lock got %0d exp 0", locked); end
      gen(4, 4, 3);
      checks++; if (duty_ok !== 1'b1) begin errors++; $display("FAIL duty_good got %0d exp 1", duty_ok); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL duty_lock got %0d exp 1", locked); end
   endtask
`endif

   initial begin
      test_reset();
      test_div2();
      test_div8();
      test_mismatch();
      test_timeout();
      test_idle_stuck();
      test_max_period();
      test_reset_mid();
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
      test_duty();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
